// File: rtl/carbon_irq_pkg.sv
// Shared types for the interrupt-controller CSR arbiter: FSM states, CSR payload structs and
// well-known CSR addresses.
package carbon_irq_pkg;

   localparam int unsigned CSR_ADDR_W = 12;
   localparam int unsigned CSR_DATA_W = 32;
   localparam int unsigned CSR_PRIV_W = 2;

   localparam logic [CSR_ADDR_W-1:0] CARBON_CSR_IE = 12'h304;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDeliver
   } irq_arb_state_e;

   typedef struct packed {
      logic                    write;
      logic [CSR_ADDR_W-1:0]   addr;
      logic [CSR_DATA_W-1:0]   wdata;
      logic [CSR_DATA_W/8-1:0] wstrb;
      logic [CSR_PRIV_W-1:0]   priv;
   } csr_req_t;

   typedef struct packed {
      logic [CSR_DATA_W-1:0] rdata;
      logic                  fault;
      logic                  side_effect;
   } csr_rsp_t;

endpackage

// File: rtl/carbon_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module carbon_rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant,
   output logic             grant_valid
);

   int unsigned idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!grant_valid && req[idx]) begin
            grant       = IDX_W'(idx);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_csr_arb.sv
// Round-robin arbiter sharing the IRQ controller CSR port between N_REQ harts, one transaction in
// flight. Optional response watchdog enabled by defining CARBON_IRQ_ARB_TIMEOUT_EN.
module irq_csr_arb
   import carbon_irq_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned ADDR_W         = CSR_ADDR_W,
   parameter int unsigned DATA_W         = CSR_DATA_W,
   parameter int unsigned PRIV_W         = CSR_PRIV_W,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_REQ-1:0]                   s_req_valid,
   output logic [N_REQ-1:0]                   s_req_ready,
   input  logic [N_REQ-1:0]                   s_req_write,
   input  logic [N_REQ-1:0][ADDR_W-1:0]       s_req_addr,
   input  logic [N_REQ-1:0][DATA_W-1:0]       s_req_wdata,
   input  logic [N_REQ-1:0][DATA_W/8-1:0]     s_req_wstrb,
   input  logic [N_REQ-1:0][PRIV_W-1:0]       s_req_priv,
   output logic [N_REQ-1:0]                   s_rsp_valid,
   input  logic [N_REQ-1:0]                   s_rsp_ready,
   output logic [DATA_W-1:0]                  s_rsp_rdata,
   output logic                               s_rsp_fault,
   output logic                               s_rsp_side_effect,
   output logic                               m_req_valid,
   input  logic                               m_req_ready,
   output logic                               m_req_write,
   output logic [ADDR_W-1:0]                  m_req_addr,
   output logic [DATA_W-1:0]                  m_req_wdata,
   output logic [DATA_W/8-1:0]                m_req_wstrb,
   output logic [PRIV_W-1:0]                  m_req_priv,
   input  logic                               m_rsp_valid,
   output logic                               m_rsp_ready,
   input  logic [DATA_W-1:0]                  m_rsp_rdata,
   input  logic                               m_rsp_fault,
   input  logic                               m_rsp_side_effect
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   irq_arb_state_e   state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   csr_req_t         req_q, req_d;
   csr_rsp_t         rsp_q, rsp_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;
   logic             idle_block;

   carbon_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req         (s_req_valid),
      .ptr         (ptr_q),
      .grant       (pick_idx),
      .grant_valid (pick_valid)
   );

`ifdef CARBON_IRQ_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drop_q, drop_d;

   // A timed-out response may still arrive later; hold off new grants until it is swallowed.
   assign idle_block = drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
      end
   end
`else
   assign idle_block = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gidx_d      = gidx_q;
      req_d       = req_q;
      rsp_d       = rsp_q;
      s_req_ready = '0;
      s_rsp_valid = '0;
      m_req_valid = 1'b0;
      m_rsp_ready = 1'b0;
`ifdef CARBON_IRQ_ARB_TIMEOUT_EN
      cnt_d  = '0;
      drop_d = drop_q;
      if (drop_q) begin
         m_rsp_ready = 1'b1;
         if (m_rsp_valid) begin
            drop_d = 1'b0;
         end
      end
`endif
      unique case (state_q)
         StIdle: begin
            if (!rst && pick_valid && !idle_block) begin
               s_req_ready[pick_idx] = 1'b1;
               gidx_d                = pick_idx;
               req_d.write           = s_req_write[pick_idx];
               req_d.addr            = CSR_ADDR_W'(s_req_addr[pick_idx]);
               req_d.wdata           = CSR_DATA_W'(s_req_wdata[pick_idx]);
               req_d.wstrb           = (CSR_DATA_W/8)'(s_req_wstrb[pick_idx]);
               req_d.priv            = CSR_PRIV_W'(s_req_priv[pick_idx]);
               ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
               state_d = StIssue;
            end
         end
         StIssue: begin
            m_req_valid = 1'b1;
            if (m_req_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            m_rsp_ready = 1'b1;
            if (m_rsp_valid) begin
               rsp_d.rdata       = CSR_DATA_W'(m_rsp_rdata);
               rsp_d.fault       = m_rsp_fault;
               rsp_d.side_effect = m_rsp_side_effect;
               state_d           = StDeliver;
            end
`ifdef CARBON_IRQ_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_d.rdata       = '0;
               rsp_d.fault       = 1'b1;
               rsp_d.side_effect = 1'b0;
               drop_d            = 1'b1;
               state_d           = StDeliver;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         StDeliver: begin
            s_rsp_valid[gidx_q] = 1'b1;
            if (s_rsp_ready[gidx_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         gidx_q  <= '0;
         req_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         req_q   <= req_d;
         rsp_q   <= rsp_d;
      end
   end

   assign m_req_write       = req_q.write;
   assign m_req_addr        = ADDR_W'(req_q.addr);
   assign m_req_wdata       = DATA_W'(req_q.wdata);
   assign m_req_wstrb       = (DATA_W/8)'(req_q.wstrb);
   assign m_req_priv        = PRIV_W'(req_q.priv);
   assign s_rsp_rdata       = DATA_W'(rsp_q.rdata);
   assign s_rsp_fault       = rsp_q.fault;
   assign s_rsp_side_effect = rsp_q.side_effect;

endmodule
